// File: rtl/param_counter.sv
// Up/down counter modulo a runtime limit with wrap/saturate modes, load, enable,
// terminal flag and a registered wrap pulse. Optional prescaler: PARAM_COUNTER_PRESCALER_EN.
module param_counter #(
  parameter int WIDTH = 4,
  parameter int PSC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [PSC_W-1:0] psc_div,
  output logic [WIDTH-1:0] count,
  output logic             at_term,
  output logic             wrap
);

  logic             tick;
  logic             at_term_c;
  logic [WIDTH-1:0] count_nxt;

  // Counting up uses >= so a loaded value above the limit is still terminal.
  assign at_term_c = up_dn ? (count >= limit) : (count == '0);
  assign at_term   = at_term_c;

`ifdef PARAM_COUNTER_PRESCALER_EN
  logic [PSC_W-1:0] psc;

  assign tick = en && (psc == psc_div);

  // psc free-wraps when psc_div drops below it, delaying the next tick.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      psc <= '0;
    end else if (tick) begin
      psc <= '0;
    end else if (en) begin
      psc <= psc + 1'b1;
    end
  end
`else
  logic unused_psc_div;

  assign unused_psc_div = ^psc_div;
  assign tick           = en;
`endif

  always_comb begin
    count_nxt = count;
    if (tick) begin
      if (!at_term_c) begin
        count_nxt = up_dn ? (count + 1'b1) : (count - 1'b1);
      end else if (sat) begin
        count_nxt = up_dn ? limit : '0;
      end else begin
        count_nxt = up_dn ? '0 : limit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= tick && at_term_c;
    end
  end

endmodule

// File: doc/param_counter.md
Name: param_counter

Overview:
- Parametrised successor to the 4-bit free-running counter driven onto the dedicated outputs.
- Counts up or down, modulo a runtime limit.
- Supports wrap or saturate mode, synchronous load, count enable, terminal-count flag and a registered wrap pulse.
- Sits between the top-level pin mapping and the display/output logic; `count` feeds the output pins.

Parameters:
- WIDTH, 4: counter width in bits (≥2).
- PSC_W, 4: prescaler width in bits; used only with PRESCALER_EN.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- en  input  1  count enable
- up_dn  input  1  1 = count up, 0 = count down
- sat  input  1  1 = saturate at bounds, 0 = wrap
- load  input  1  synchronous load strobe
- load_val  input  WIDTH  value loaded on `load`
- limit  input  WIDTH  upper bound (modulo limit+1); sampled every cycle
- psc_div  input  PSC_W  prescale divisor minus 1; ignored without PRESCALER_EN
- count  output  WIDTH  current count
- at_term  output  1  combinational: count at terminal for the current direction
- wrap  output  1  registered one-cycle pulse after a terminal tick

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous and active-high. All state updates on rising `clk`.
- Reset: count=0, wrap=0, prescaler=0. `rst` overrides `load` and `en`. Mid-count reset takes effect on the next edge with no partial update.
- Priority per edge: rst > load > tick > hold.
- tick = en (without prescaler; see Optional Feature).
- Terminal condition:
  - up_dn=1: terminal when count ≥ limit; the ≥ covers load_val > limit.
  - up_dn=0: terminal when count == 0.
  - at_term reflects this every cycle, independent of en.
- Tick, not terminal: up → count+1; down → count−1.
- Tick, terminal, sat=0:
  - Up → 0.
  - Down → limit.
  - limit=0: count stays 0.
- Tick, terminal, sat=1:
  - Up → count unchanged if count==limit. If count>limit, count is set to limit.
  - Down → holds 0.
- wrap: set to 1 on the edge following any tick where the terminal condition held (wrap or saturate mode); otherwise 0. It is a single-cycle pulse unless terminal ticks are consecutive (saturate hold, limit=0); it then stays high while they continue.
- load: count ← load_val unclamped; wrap ← 0; prescaler ← 0. Load takes priority over a simultaneous tick.
- Direction/limit changes apply to the next tick; no pipeline, latency 1 cycle from tick to new count.
- Arithmetic modulo 2^WIDTH, but natural overflow is unreachable because terminal detection precedes increment.

Optional Feature:
- Macro: PARAM_COUNTER_PRESCALER_EN.
- Defined:
  - A PSC_W-bit prescaler `psc` increments on each cycle with en=1.
  - tick = en && (psc == psc_div); psc ← 0 on tick.
  - psc holds when en=0.
  - psc clears on rst or load.
  - psc_div=0 gives tick = en.
  - If psc_div changes to a value below the current psc, psc counts up and wraps through 2^PSC_W before the next tick.
- Not defined: no prescaler logic; psc_div is unused (no functional effect); tick = en.

Test Plan:
1. WIDTH=4, rst=1 for 2 cycles, then en=1, up_dn=1, sat=0, limit=9 for 12 cycles → count 0..9,0,1; wrap high exactly the cycle count shows 0 after 9; at_term high while count=9.
2. up_dn=0, sat=0, limit=9, load load_val=2, then en=1 → count 2,1,0,9,8; wrap pulses when count becomes 9.
3. sat=1, up_dn=1, limit=5, from count=4, en=1 for 4 cycles → 5,5,5,5; wrap stays high from the cycle count holds at 5 while en=1. Then load load_val=12 with up → next tick count=5.
4. load=1 and en=1 in the same cycle at count=7, load_val=3 → count=3, wrap=0. Assert rst mid-count (count=6) with load=1 → count=0.
5. en toggling 1,0,0,1 from count=0, limit=15 → 1,1,1,2; at_term stays 0.
6. With PARAM_COUNTER_PRESCALER_EN, psc_div=2, en=1 continuously, limit=3 → count advances every 3rd cycle: 0,0,0,1,1,1,2…; load clears psc so the next increment comes 3 cycles after load.
